// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared types and constants for the PDP-8 fetch/decode stage.
//   - decoder FSM state encoding (decode_state_e)
//   - memory-reference and operate-group flag structures
//   - major opcodes, exact-match operate microinstruction words
//   - auto-index window and small helper functions
package pdp8_pkg;

    // Decoder FSM state encoding
    typedef logic [3:0] decode_state_e;
    localparam decode_state_e S_IDLE       = 4'd0;
    localparam decode_state_e S_FETCH      = 4'd1;
    localparam decode_state_e S_FETCH_WAIT = 4'd2;
    localparam decode_state_e S_DECODE     = 4'd3;
    localparam decode_state_e S_IND_REQ    = 4'd4;
    localparam decode_state_e S_IND_WAIT   = 4'd5;
    localparam decode_state_e S_AUTO_WR    = 4'd6;
    localparam decode_state_e S_ISSUE      = 4'd7;
    localparam decode_state_e S_RETIRE     = 4'd8;
    localparam decode_state_e S_HALT       = 4'd9;

    // Major opcodes (IR[11:9])
    localparam logic [2:0] OP_AND = 3'o0;
    localparam logic [2:0] OP_TAD = 3'o1;
    localparam logic [2:0] OP_ISZ = 3'o2;
    localparam logic [2:0] OP_DCA = 3'o3;
    localparam logic [2:0] OP_JMS = 3'o4;
    localparam logic [2:0] OP_JMP = 3'o5;
    localparam logic [2:0] OP_IOT = 3'o6;
    localparam logic [2:0] OP_OPR = 3'o7;

    // Group-1 operate words
    localparam logic [11:0] OP7_NOP     = 12'o7000;
    localparam logic [11:0] OP7_IAC     = 12'o7001;
    localparam logic [11:0] OP7_RAL     = 12'o7004;
    localparam logic [11:0] OP7_RTL     = 12'o7006;
    localparam logic [11:0] OP7_RAR     = 12'o7010;
    localparam logic [11:0] OP7_RTR     = 12'o7012;
    localparam logic [11:0] OP7_CML     = 12'o7020;
    localparam logic [11:0] OP7_CMA     = 12'o7040;
    localparam logic [11:0] OP7_CIA     = 12'o7041;
    localparam logic [11:0] OP7_CLL     = 12'o7100;
    localparam logic [11:0] OP7_CLA1    = 12'o7200;
    localparam logic [11:0] OP7_CLA_CLL = 12'o7300;
    // Group-2 operate words
    localparam logic [11:0] OP7_HLT     = 12'o7402;
    localparam logic [11:0] OP7_OSR     = 12'o7404;
    localparam logic [11:0] OP7_SKP     = 12'o7410;
    localparam logic [11:0] OP7_SNL     = 12'o7420;
    localparam logic [11:0] OP7_SZL     = 12'o7430;
    localparam logic [11:0] OP7_SZA     = 12'o7440;
    localparam logic [11:0] OP7_SNA     = 12'o7450;
    localparam logic [11:0] OP7_SMA     = 12'o7500;
    localparam logic [11:0] OP7_SPA     = 12'o7510;
    localparam logic [11:0] OP7_CLA2    = 12'o7600;

    // Auto-index pointer window
    localparam logic [11:0] AUTO_LO = 12'o0010;
    localparam logic [11:0] AUTO_HI = 12'o0017;

    typedef struct packed {
        logic        AND;
        logic        TAD;
        logic        ISZ;
        logic        DCA;
        logic        JMS;
        logic        JMP;
        logic [11:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

    function automatic logic is_auto_index(input logic [11:0] addr);
        return (addr >= AUTO_LO) && (addr <= AUTO_HI);
    endfunction

    // 12-bit wrap-around increment (7777 -> 0000)
    function automatic logic [11:0] inc12(input logic [11:0] value);
        return value + 12'd1;
    endfunction

endpackage

// File: rtl/instr_decode_if.sv
// instr_decode_if: memory port of the fetch/decode stage.
//   master (decoder): drives read/write requests, addresses and write data.
//   slave  (memory) : returns read data one cycle after a read request.
interface instr_decode_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) ();
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [DATA_WIDTH-1:0] ifu_rd_data;
    logic                  ifu_wr_req;
    logic [ADDR_WIDTH-1:0] ifu_wr_addr;
    logic [DATA_WIDTH-1:0] ifu_wr_data;

    modport master (
        output ifu_rd_req, ifu_rd_addr, ifu_wr_req, ifu_wr_addr, ifu_wr_data,
        input  ifu_rd_data
    );

    modport slave (
        input  ifu_rd_req, ifu_rd_addr, ifu_wr_req, ifu_wr_addr, ifu_wr_data,
        output ifu_rd_data
    );
endinterface

// File: rtl/pdp8_word_decode.sv
// pdp8_word_decode: purely combinational classification of an instruction word.
//   ir      : 12-bit instruction register
//   mem_op  : memory-reference flag (address field left zero, filled by caller)
//   op7_op  : operate microinstruction flag, exact-match decode
//   illegal : word is IOT or an unsupported operate combination (decoded as NOP)
import pdp8_pkg::*;

module pdp8_word_decode (
    input  logic [11:0]     ir,
    output pdp_mem_opcode_s mem_op,
    output pdp_op7_opcode_s op7_op,
    output logic            illegal
);

    // Opcode and microinstruction classification
    always_comb begin
        mem_op  = '0;
        op7_op  = '0;
        illegal = 1'b0;
        case (ir[11:9])
            OP_AND: mem_op.AND = 1'b1;
            OP_TAD: mem_op.TAD = 1'b1;
            OP_ISZ: mem_op.ISZ = 1'b1;
            OP_DCA: mem_op.DCA = 1'b1;
            OP_JMS: mem_op.JMS = 1'b1;
            OP_JMP: mem_op.JMP = 1'b1;
            OP_IOT: begin
                op7_op.NOP = 1'b1;
                illegal    = 1'b1;
            end
            OP_OPR: begin
                case (ir)
                    OP7_NOP:     op7_op.NOP     = 1'b1;
                    OP7_IAC:     op7_op.IAC     = 1'b1;
                    OP7_RAL:     op7_op.RAL     = 1'b1;
                    OP7_RTL:     op7_op.RTL     = 1'b1;
                    OP7_RAR:     op7_op.RAR     = 1'b1;
                    OP7_RTR:     op7_op.RTR     = 1'b1;
                    OP7_CML:     op7_op.CML     = 1'b1;
                    OP7_CMA:     op7_op.CMA     = 1'b1;
                    OP7_CIA:     op7_op.CIA     = 1'b1;
                    OP7_CLL:     op7_op.CLL     = 1'b1;
                    OP7_CLA1:    op7_op.CLA1    = 1'b1;
                    OP7_CLA_CLL: op7_op.CLA_CLL = 1'b1;
                    OP7_HLT:     op7_op.HLT     = 1'b1;
                    OP7_OSR:     op7_op.OSR     = 1'b1;
                    OP7_SKP:     op7_op.SKP     = 1'b1;
                    OP7_SNL:     op7_op.SNL     = 1'b1;
                    OP7_SZL:     op7_op.SZL     = 1'b1;
                    OP7_SZA:     op7_op.SZA     = 1'b1;
                    OP7_SNA:     op7_op.SNA     = 1'b1;
                    OP7_SMA:     op7_op.SMA     = 1'b1;
                    OP7_SPA:     op7_op.SPA     = 1'b1;
                    OP7_CLA2:    op7_op.CLA2    = 1'b1;
                    default: begin
                        op7_op.NOP = 1'b1;
                        illegal    = 1'b1;
                    end
                endcase
            end
            default: begin
                mem_op  = '0;
                op7_op  = '0;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode.sv
// instr_decode: PDP-8 instruction fetch/decode stage.
//   clk, reset (async, active high)
//   stall / PC_value : retire handshake from the execute unit
//   base_addr        : constant START_ADDR
//   pdp_mem_opcode   : memory-reference flag + effective address
//   pdp_op7_opcode   : operate microinstruction flag
//   ifu              : memory port (read/write request, address, data)
//   illegal_instr    : one-cycle pulse when an unsupported word is issued
//   halted           : sticky, set once HLT retires
import pdp8_pkg::*;

module instr_decode #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o0200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    instr_decode_if.master        ifu,
    output logic                  illegal_instr,
    output logic                  halted
);

    decode_state_e         state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] ir_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] ptr_r;
    pdp_mem_opcode_s       mem_op_r;
    pdp_op7_opcode_s       op7_r;
    logic                  illegal_r;
    logic                  halted_r;
    logic                  rd_req_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic                  wr_req_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;

    pdp_mem_opcode_s       dec_mem_s;
    pdp_op7_opcode_s       dec_op7_s;
    logic                  dec_illegal_s;
    logic                  is_mem_s;
    logic                  indirect_s;
    logic [ADDR_WIDTH-1:0] direct_addr_s;
    logic [ADDR_WIDTH-1:0] ea_s;
    pdp_mem_opcode_s       mem_issue_s;

    pdp8_word_decode u_word_decode (
        .ir      (ir_r),
        .mem_op  (dec_mem_s),
        .op7_op  (dec_op7_s),
        .illegal (dec_illegal_s)
    );

    // Operand address: page zero, or the page of the instruction itself
    always_comb begin
        is_mem_s   = (ir_r[11:9] != OP_IOT) && (ir_r[11:9] != OP_OPR);
        indirect_s = ir_r[8];
        if (ir_r[7]) begin
            direct_addr_s = {pc_r[11:7], ir_r[6:0]};
        end else begin
            direct_addr_s = {5'b00000, ir_r[6:0]};
        end
    end

    // Effective address depends on which path reaches ISSUE
    always_comb begin
        case (state_r)
            S_DECODE:   ea_s = direct_addr_s;
            S_IND_WAIT: ea_s = ifu.ifu_rd_data;
            S_AUTO_WR:  ea_s = ptr_r;
            default:    ea_s = '0;
        endcase
        mem_issue_s               = dec_mem_s;
        mem_issue_s.mem_inst_addr = ea_s;
    end

    // Fetch/decode FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            pc_r      <= START_ADDR;
            ir_r      <= '0;
            addr_r    <= '0;
            ptr_r     <= '0;
            mem_op_r  <= '0;
            op7_r     <= '0;
            illegal_r <= 1'b0;
            halted_r  <= 1'b0;
            rd_req_r  <= 1'b0;
            rd_addr_r <= '0;
            wr_req_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            // illegal_instr is a pulse; only the DECODE->ISSUE edge raises it
            illegal_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    rd_req_r  <= 1'b1;
                    rd_addr_r <= pc_r;
                    state_r   <= S_FETCH;
                end
                S_FETCH: begin
                    rd_req_r <= 1'b0;
                    state_r  <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    ir_r    <= ifu.ifu_rd_data;
                    state_r <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_mem_s && indirect_s) begin
                        addr_r    <= direct_addr_s;
                        rd_req_r  <= 1'b1;
                        rd_addr_r <= direct_addr_s;
                        state_r   <= S_IND_REQ;
                    end else if (is_mem_s) begin
                        mem_op_r <= mem_issue_s;
                        state_r  <= S_ISSUE;
                    end else begin
                        op7_r     <= dec_op7_s;
                        illegal_r <= dec_illegal_s;
                        state_r   <= S_ISSUE;
                    end
                end
                S_IND_REQ: begin
                    rd_req_r <= 1'b0;
                    state_r  <= S_IND_WAIT;
                end
                S_IND_WAIT: begin
                    if (is_auto_index(addr_r)) begin
                        ptr_r     <= inc12(ifu.ifu_rd_data);
                        wr_req_r  <= 1'b1;
                        wr_addr_r <= addr_r;
                        wr_data_r <= inc12(ifu.ifu_rd_data);
                        state_r   <= S_AUTO_WR;
                    end else begin
                        mem_op_r <= mem_issue_s;
                        state_r  <= S_ISSUE;
                    end
                end
                S_AUTO_WR: begin
                    wr_req_r <= 1'b0;
                    mem_op_r <= mem_issue_s;
                    state_r  <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (stall) begin
                        state_r <= S_RETIRE;
                    end else begin
                        state_r <= S_ISSUE;
                    end
                end
                S_RETIRE: begin
                    if (!stall) begin
                        mem_op_r <= '0;
                        op7_r    <= '0;
                        pc_r     <= PC_value;
                        if (op7_r.HLT) begin
                            halted_r <= 1'b1;
                            state_r  <= S_HALT;
                        end else begin
                            rd_req_r  <= 1'b1;
                            rd_addr_r <= PC_value;
                            state_r   <= S_FETCH;
                        end
                    end else begin
                        state_r <= S_RETIRE;
                    end
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    state_r  <= S_IDLE;
                    rd_req_r <= 1'b0;
                    wr_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign base_addr       = START_ADDR;
    assign pdp_mem_opcode  = mem_op_r;
    assign pdp_op7_opcode  = op7_r;
    assign illegal_instr   = illegal_r;
    assign halted          = halted_r;
    assign ifu.ifu_rd_req  = rd_req_r;
    assign ifu.ifu_rd_addr = rd_addr_r;
    assign ifu.ifu_wr_req  = wr_req_r;
    assign ifu.ifu_wr_addr = wr_addr_r;
    assign ifu.ifu_wr_data = wr_data_r;

endmodule
